ras_ckpt: RTL and testbench

//  Parametrised return-address stack with per-branch checkpoints for the branch unit.

---
 rtl/ras_ckpt.sv | 211 +++++++++++++++++++++
 tb/tb_ras_ckpt.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt -- return-address stack with per-branch checkpoints.
//
// Calls push a return address and returns pop one. The top of stack is
// presented, registered, as the predicted return address for fetch. Every issued
// branch may take a checkpoint of the pre-cycle stack pointer, occupancy and top
// entry. Branches commit in order: a correct prediction releases the oldest
// checkpoint, and a misprediction restores the stack from the oldest checkpoint
// and discards all of them.
//
// Ports
//   i_clk          clock
//   i_reset        synchronous active-high reset (empties stack and checkpoints)
//   i_push         call issued this cycle
//   i_push_addr    return address to push
//   i_pop          return issued this cycle
//   i_ckpt_valid   branch issue requests a checkpoint
//   o_ckpt_ready   a checkpoint can be taken this cycle
//   i_release      oldest branch committed with a correct prediction
//   i_flush        oldest branch committed mispredicted; restore from its checkpoint
//   o_ret_addr     predicted return address (top of stack)
//   o_ret_valid    occupancy is non-zero
//   o_ckpt_count   number of live checkpoints
//   o_overflow     sticky: push-only while the stack was full
//   o_underflow    sticky: pop-only while the stack was empty
module ras_ckpt #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16,
  parameter int N_CKPT = 4,
  localparam int SP_W  = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int CNT_W = $clog2(N_CKPT + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic              i_pop,
  input  logic              i_ckpt_valid,
  output logic              o_ckpt_ready,
  input  logic              i_release,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic              o_ret_valid,
  output logic [CNT_W-1:0]  o_ckpt_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_CKPT);

  // Stack storage is deliberately not reset; occupancy says which entries matter.
  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [OCC_W-1:0]  r_occ;

  // Checkpoint FIFO as a shift register; index 0 is always the oldest branch.
  logic [SP_W-1:0]   r_ck_sp  [N_CKPT];
  logic [OCC_W-1:0]  r_ck_occ [N_CKPT];
  logic [ADDR_W-1:0] r_ck_top [N_CKPT];
  logic [CNT_W-1:0]  r_ckpt_count;

  logic [ADDR_W-1:0] r_ret_addr;
  logic              r_ret_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_ckpt_ready;
  logic              w_rel_eff;
  logic              w_alloc;
  logic              w_flush_eff;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [SP_W-1:0]   w_sp_next;
  logic [OCC_W-1:0]  w_occ_next;
  logic              w_we;
  logic [SP_W-1:0]   w_waddr;
  logic [ADDR_W-1:0] w_wdata;
  logic              w_set_ov;
  logic              w_set_un;
  logic [ADDR_W-1:0] w_ret_next;

  // Checkpoint handshake and FIFO bookkeeping; flush overrides alloc and release.
  always_comb begin
    w_ckpt_ready = (r_ckpt_count < CNT_MAX) || i_release;
    w_rel_eff    = i_release && (r_ckpt_count != CNT_W'(0)) && !i_flush;
    w_alloc      = i_ckpt_valid && w_ckpt_ready && !i_flush;
    w_flush_eff  = i_flush && (r_ckpt_count != CNT_W'(0));
    // A same-cycle release shifts the FIFO first, so the new entry lands one slot lower.
    w_wr_idx     = r_ckpt_count - CNT_W'(w_rel_eff);
    if (i_flush) begin
      w_cnt_next = CNT_W'(0);
    end else begin
      case ({w_alloc, w_rel_eff})
        2'b10:   w_cnt_next = r_ckpt_count + CNT_W'(1);
        2'b01:   w_cnt_next = r_ckpt_count - CNT_W'(1);
        default: w_cnt_next = r_ckpt_count;
      endcase
    end
  end

  // Next stack pointer, occupancy and single stack write for this cycle.
  always_comb begin
    w_sp_next  = r_sp;
    w_occ_next = r_occ;
    w_we       = 1'b0;
    w_waddr    = r_sp;
    w_wdata    = i_push_addr;
    w_set_ov   = 1'b0;
    w_set_un   = 1'b0;
    if (w_flush_eff) begin
      // Only the checkpointed top entry is rewritten; deeper entries are trusted.
      w_sp_next  = r_ck_sp[0];
      w_occ_next = r_ck_occ[0];
      w_we       = 1'b1;
      w_waddr    = r_ck_sp[0];
      w_wdata    = r_ck_top[0];
    end else if (i_flush) begin
      // Nothing to restore from: hold the stack as it is.
      w_sp_next  = r_sp;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          w_sp_next  = r_sp + SP_W'(1);
          w_we       = 1'b1;
          w_waddr    = r_sp + SP_W'(1);
          w_set_ov   = (r_occ == OCC_FULL);
          w_occ_next = (r_occ == OCC_FULL) ? r_occ : r_occ + OCC_W'(1);
        end
        2'b01: begin
          // The pointer keeps moving even on an empty stack.
          w_sp_next  = r_sp - SP_W'(1);
          w_set_un   = (r_occ == OCC_W'(0));
          w_occ_next = (r_occ == OCC_W'(0)) ? r_occ : r_occ - OCC_W'(1);
        end
        2'b11: begin
          w_we       = 1'b1;
          w_waddr    = r_sp;
          w_occ_next = (r_occ == OCC_W'(0)) ? OCC_W'(1) : r_occ;
        end
        default: begin
          w_sp_next  = r_sp;
        end
      endcase
    end
    // Forward the write so the new top is visible one cycle after the push.
    if (w_we && (w_waddr == w_sp_next)) begin
      w_ret_next = w_wdata;
    end else begin
      w_ret_next = r_stack[w_sp_next];
    end
  end

  // Stack entry write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_we) begin
      r_stack[w_waddr] <= w_wdata;
    end
  end

  // Checkpoint FIFO shift on release and capture of pre-cycle state on alloc.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush) begin
      if (w_rel_eff) begin
        for (int i = 0; i < N_CKPT - 1; i++) begin
          r_ck_sp[i]  <= r_ck_sp[i+1];
          r_ck_occ[i] <= r_ck_occ[i+1];
          r_ck_top[i] <= r_ck_top[i+1];
        end
      end
      if (w_alloc) begin
        for (int i = 0; i < N_CKPT; i++) begin
          if (CNT_W'(i) == w_wr_idx) begin
            r_ck_sp[i]  <= r_sp;
            r_ck_occ[i] <= r_occ;
            r_ck_top[i] <= r_stack[r_sp];
          end
        end
      end
    end
  end

  // Pointer, occupancy, checkpoint count, registered outputs and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sp         <= SP_W'(DEPTH - 1);
      r_occ        <= OCC_W'(0);
      r_ckpt_count <= CNT_W'(0);
      r_ret_addr   <= ADDR_W'(0);
      r_ret_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_sp         <= w_sp_next;
      r_occ        <= w_occ_next;
      r_ckpt_count <= w_cnt_next;
      r_ret_addr   <= w_ret_next;
      r_ret_valid  <= (w_occ_next != OCC_W'(0));
      r_overflow   <= r_overflow | w_set_ov;
      r_underflow  <= r_underflow | w_set_un;
    end
  end

  assign o_ckpt_ready = w_ckpt_ready;
  assign o_ret_addr   = r_ret_addr;
  assign o_ret_valid  = r_ret_valid;
  assign o_ckpt_count = r_ckpt_count;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt -- directed scenarios plus randomized traffic for ras_ckpt,
// checked every cycle against a behavioural stack/queue model.
module tb_ras_ckpt;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16;
  localparam int N_CKPT = 4;
  localparam int CNT_W  = $clog2(N_CKPT + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic              pop;
  logic              cv;
  logic              cready;
  logic              rel;
  logic              fl;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid;
  logic [CNT_W-1:0]  ckpt_count;
  logic              ovf;
  logic              unf;

  int n_checks = 0;
  int n_errors = 0;

  ras_ckpt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_CKPT(N_CKPT)) dut (
    .i_clk(clk), .i_reset(rst), .i_push(push), .i_push_addr(push_addr),
    .i_pop(pop), .i_ckpt_valid(cv), .o_ckpt_ready(cready), .i_release(rel),
    .i_flush(fl), .o_ret_addr(ret_addr), .o_ret_valid(ret_valid),
    .o_ckpt_count(ckpt_count), .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int              sp;
    int              occ;
    logic [ADDR_W-1:0] top;
  } ck_t;

  logic [ADDR_W-1:0] m_stk [DEPTH];
  int                m_sp;
  int                m_occ;
  ck_t               m_q [$];
  logic [ADDR_W-1:0] m_ret;
  bit                m_rv, m_ov, m_un, m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_q.size() < N_CKPT) || rel;
  endfunction

  task automatic model_step();
    ck_t pre;
    ck_t e;
    bit  rdy;
    if (rst) begin
      m_sp = DEPTH - 1; m_occ = 0; m_q.delete();
      m_ret = '0; m_rv = 0; m_ov = 0; m_un = 0; m_known = 1;
    end else begin
      rdy = m_ready();
      if (fl) begin
        if (m_q.size() > 0) begin
          e = m_q[0];
          m_sp = e.sp; m_occ = e.occ; m_stk[e.sp] = e.top;
          m_q.delete();
        end
      end else begin
        pre.sp = m_sp; pre.occ = m_occ; pre.top = m_stk[m_sp];
        if (rel && m_q.size() > 0) void'(m_q.pop_front());
        if (cv && rdy) m_q.push_back(pre);
        if (push && !pop) begin
          if (m_occ == DEPTH) m_ov = 1;
          m_sp = (m_sp + 1) % DEPTH;
          m_stk[m_sp] = push_addr;
          m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH;
        end else if (pop && !push) begin
          if (m_occ == 0) m_un = 1;
          m_sp = (m_sp + DEPTH - 1) % DEPTH;
          m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        end else if (push && pop) begin
          m_stk[m_sp] = push_addr;
          m_occ = (m_occ == 0) ? 1 : m_occ;
        end
      end
      m_ret = m_stk[m_sp];
      m_rv = (m_occ != 0);
      m_known = m_rv;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    #1;
    chk("ckpt_ready", {31'd0, cready}, {31'd0, m_ready()});
    model_step();
    @(posedge clk);
    #1;
    chk("ret_valid", {31'd0, ret_valid}, {31'd0, m_rv});
    chk("ckpt_count", 32'(ckpt_count), 32'(m_q.size()));
    chk("overflow", {31'd0, ovf}, {31'd0, m_ov});
    chk("underflow", {31'd0, unf}, {31'd0, m_un});
    if (m_known) chk("ret_addr", 32'(ret_addr), 32'(m_ret));
  endtask

  task automatic drive(input bit p, input logic [ADDR_W-1:0] a, input bit o,
                       input bit c, input bit r, input bit f);
    rst = 1'b0; push = p; push_addr = a; pop = o; cv = c; rel = r; fl = f;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; cv = 1'b0; rel = 1'b0; fl = 1'b0;
    push_addr = '0;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    do_reset();
    chk("rst_cnt", 32'(ckpt_count), 32'd0);
    chk("rst_rv", {31'd0, ret_valid}, 32'd0);

    // T1: basic push/pop ordering
    drive(1, 14'h10, 0, 0, 0, 0); chk("t1_p1", 32'(ret_addr), 32'h10);
    drive(1, 14'h20, 0, 0, 0, 0); chk("t1_p2", 32'(ret_addr), 32'h20);
    drive(1, 14'h30, 0, 0, 0, 0); chk("t1_p3", 32'(ret_addr), 32'h30);
    drive(0, 14'h0, 1, 0, 0, 0);  chk("t1_o1", 32'(ret_addr), 32'h20);
    drive(0, 14'h0, 1, 0, 0, 0);  chk("t1_o2", 32'(ret_addr), 32'h10);
    drive(0, 14'h0, 1, 0, 0, 0);  chk("t1_o3", {31'd0, ret_valid}, 32'd0);

    // T2: overflow by wrap, then drain
    do_reset();
    for (int i = 1; i <= 17; i++) drive(1, 14'(i), 0, 0, 0, 0);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_top", 32'(ret_addr), 32'd17);
    for (int i = 0; i < 15; i++) drive(0, 14'h0, 1, 0, 0, 0);
    chk("t2_last", 32'(ret_addr), 32'd2);
    drive(0, 14'h0, 1, 0, 0, 0);
    chk("t2_empty", {31'd0, ret_valid}, 32'd0);
    chk("t2_unf0", {31'd0, unf}, 32'd0);
    drive(0, 14'h0, 1, 0, 0, 0);
    chk("t2_unf1", {31'd0, unf}, 32'd1);

    // T3: repair after a wrong-path pop/pop/push
    do_reset();
    drive(1, 14'hA, 0, 0, 0, 0);
    drive(1, 14'hB, 0, 1, 0, 0);
    drive(0, 14'h0, 1, 0, 0, 0);
    drive(0, 14'h0, 1, 0, 0, 0);
    drive(1, 14'hC, 0, 0, 0, 0);
    drive(0, 14'h0, 0, 0, 0, 1);
    chk("t3_ret", 32'(ret_addr), 32'hA);
    chk("t3_rv", {31'd0, ret_valid}, 32'd1);
    chk("t3_cnt", 32'(ckpt_count), 32'd0);
    drive(0, 14'h0, 1, 0, 0, 0);
    chk("t3_occ1", {31'd0, ret_valid}, 32'd0);

    // T4: full checkpoint FIFO, release+alloc together
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 14'(i * 256), 0, 0, 0, 0);
      drive(0, 14'h0, 0, 1, 0, 0);
    end
    push = 0; pop = 0; cv = 0; rel = 0; fl = 0;
    #1 chk("t4_full", {31'd0, cready}, 32'd0);
    rel = 1; cv = 1;
    #1 chk("t4_rdy", {31'd0, cready}, 32'd1);
    drive(0, 14'h0, 0, 1, 1, 0);
    chk("t4_cnt", 32'(ckpt_count), 32'd4);
    drive(0, 14'h0, 0, 0, 0, 1);
    chk("t4_ret", 32'(ret_addr), 32'h200);
    drive(0, 14'h0, 1, 0, 0, 0);
    chk("t4_pop", 32'(ret_addr), 32'h100);

    // T5: flush beats same-cycle push and alloc
    drive(1, 14'h200, 0, 0, 0, 0);
    drive(0, 14'h0, 0, 1, 0, 0);
    drive(1, 14'h500, 0, 0, 0, 0);
    drive(1, 14'h600, 0, 0, 0, 0);
    drive(1, 14'h700, 0, 1, 0, 1);
    chk("t5_ret", 32'(ret_addr), 32'h200);
    chk("t5_cnt", 32'(ckpt_count), 32'd0);
    drive(0, 14'h0, 0, 0, 0, 0);
    chk("t5_cnt2", 32'(ckpt_count), 32'd0);

    // T6: reset in the middle of activity
    do_reset();
    drive(0, 14'h0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 14'(i + 40), 0, (i < 3), 0, 0);
    chk("t6_pre", 32'(ckpt_count), 32'd3);
    rst = 1; push = 1; cv = 1;
    cycle();
    chk("t6_cnt", 32'(ckpt_count), 32'd0);
    chk("t6_rv", {31'd0, ret_valid}, 32'd0);
    chk("t6_ret", 32'(ret_addr), 32'd0);
    chk("t6_unf", {31'd0, unf}, 32'd0);
    chk("t6_ovf", {31'd0, ovf}, 32'd0);

    // Randomized traffic with alternating push-heavy and pop-heavy phases
    for (int blk = 0; blk < 20; blk++) begin
      int p_push;
      p_push = (blk % 2 == 0) ? 75 : 30;
      for (int k = 0; k < 150; k++) begin
        rst       = ($urandom_range(0, 199) == 0);
        push      = ($urandom_range(0, 99) < p_push);
        pop       = ($urandom_range(0, 99) < (100 - p_push));
        push_addr = 14'($urandom);
        cv        = ($urandom_range(0, 99) < 35);
        rel       = ($urandom_range(0, 99) < 20);
        fl        = ($urandom_range(0, 99) < 5);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
